modulo_receptor_uart: RTL and testbench



---
 rtl/paquete_uart_pkg.sv | 19 +
 rtl/sincronizador_entrada.sv | 25 ++
 rtl/modulo_receptor_uart.sv | 157 +++++++++++++++
 tb/tb_modulo_receptor_uart.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/paquete_uart_pkg.sv
// Shared definitions for the inter-FPGA UART link: receiver states,
// packet geometry and the default bit timing for 50 MHz / 9600 baud.
package paquete_uart_pkg;

    localparam int ANCHO_PAQUETE          = 8;
    localparam int ANCHO_CAMPO            = 4;
    localparam int POS_DESTINO            = 4;
    localparam int POS_DATO               = 0;
    localparam int CICLOS_POR_BIT_DEFECTO = 5208;

    typedef enum logic [2:0] {
        ESPERA,
        INICIO,
        DATOS,
        PARADA,
        RECUPERA
    } estado_receptor_t;

endpackage

// File: rtl/sincronizador_entrada.sv
// Two-flop synchronizer for an asynchronous single-bit input. Both flops
// reset to VALOR_REINICIO so the downstream logic sees a known idle level.
module sincronizador_entrada #(
    parameter logic VALOR_REINICIO = 1'b1
) (
    input  logic reloj,
    input  logic reinicio,
    input  logic entrada,
    output logic salida
);

    logic etapaUno;

    // Two-stage capture to settle metastability before use.
    always_ff @(posedge reloj or negedge reinicio) begin
        if (!reinicio) begin
            etapaUno <= VALOR_REINICIO;
            salida   <= VALOR_REINICIO;
        end else begin
            etapaUno <= entrada;
            salida   <= etapaUno;
        end
    end

endmodule

// File: rtl/modulo_receptor_uart.sv
// Receive end of the inter-FPGA UART link: deserializes one 8N1 frame into
// the packet {identificadorDestino, dato} and raises a one-cycle strobe for
// the packet processor, or a one-cycle error strobe on a bad stop bit.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ESPERA   | line idle, waiting for a falling edge (start bit)
// INICIO   | counting to mid start bit to confirm it is not a glitch
// DATOS    | sampling the 8 data bits at each bit centre, LSB first
// PARADA   | sampling the stop bit; publish packet or flag error
// RECUPERA | stop bit was low (break / framing error); wait for idle
module modulo_receptor_uart
    import paquete_uart_pkg::*;
#(
    parameter int CICLOS_POR_BIT = CICLOS_POR_BIT_DEFECTO
) (
    input  logic                     reloj,
    input  logic                     reinicio,
    input  logic                     lineaRecepcionBits,
    output logic [ANCHO_PAQUETE-1:0] bitsRecibidos,
    output logic [ANCHO_CAMPO-1:0]   identificadorDestino,
    output logic [ANCHO_CAMPO-1:0]   datoRecibido,
    output logic                     recepcionFinalizada,
    output logic                     errorTrama
);

    localparam int ANCHO_CICLO = $clog2(CICLOS_POR_BIT);
    localparam logic [ANCHO_CICLO-1:0] CICLO_MEDIO = ANCHO_CICLO'(CICLOS_POR_BIT / 2 - 1);
    localparam logic [ANCHO_CICLO-1:0] CICLO_FINAL = ANCHO_CICLO'(CICLOS_POR_BIT - 1);
    localparam logic [ANCHO_CICLO-1:0] CICLO_UNO   = ANCHO_CICLO'(1);
    localparam logic [2:0]             INDICE_ULTIMO = 3'd7;

    logic                     rxS;
    estado_receptor_t         estado;
    estado_receptor_t         estadoSig;
    logic [ANCHO_CICLO-1:0]   ciclo;
    logic [ANCHO_CICLO-1:0]   cicloSig;
    logic [2:0]               indice;
    logic [2:0]               indiceSig;
    logic [ANCHO_PAQUETE-1:0] desplazamiento;
    logic [ANCHO_PAQUETE-1:0] desplazamientoSig;
    logic [ANCHO_PAQUETE-1:0] bitsSig;
    logic                     finalizadaSig;
    logic                     errorSig;

    sincronizador_entrada #(
        .VALOR_REINICIO(1'b1)
    ) uSincronizador (
        .reloj   (reloj),
        .reinicio(reinicio),
        .entrada (lineaRecepcionBits),
        .salida  (rxS)
    );

    // Next-state and datapath decisions; strobes are registered so both
    // they and bitsRecibidos change on the same edge.
    always_comb begin
        estadoSig         = estado;
        cicloSig          = ciclo + CICLO_UNO;
        indiceSig         = indice;
        desplazamientoSig = desplazamiento;
        bitsSig           = bitsRecibidos;
        finalizadaSig     = 1'b0;
        errorSig          = 1'b0;

        case (estado)
            ESPERA: begin
                cicloSig = '0;
                if (!rxS) begin
                    estadoSig = INICIO;
                end
            end

            INICIO: begin
                if (ciclo == CICLO_MEDIO) begin
                    cicloSig = '0;
                    if (!rxS) begin
                        estadoSig = DATOS;
                        indiceSig = '0;
                    end else begin
                        estadoSig = ESPERA;
                    end
                end
            end

            DATOS: begin
                if (ciclo == CICLO_FINAL) begin
                    cicloSig          = '0;
                    desplazamientoSig = {rxS, desplazamiento[ANCHO_PAQUETE-1:1]};
                    if (indice == INDICE_ULTIMO) begin
                        estadoSig = PARADA;
                    end else begin
                        indiceSig = indice + 3'd1;
                    end
                end
            end

            PARADA: begin
                if (ciclo == CICLO_FINAL) begin
                    cicloSig = '0;
                    if (rxS) begin
                        bitsSig       = desplazamiento;
                        finalizadaSig = 1'b1;
                        estadoSig     = ESPERA;
                    end else begin
                        errorSig  = 1'b1;
                        estadoSig = RECUPERA;
                    end
                end
            end

            RECUPERA: begin
                cicloSig = '0;
                if (rxS) begin
                    estadoSig = ESPERA;
                end
            end

            default: begin
                cicloSig  = '0;
                estadoSig = ESPERA;
            end
        endcase
    end

    // State register.
    always_ff @(posedge reloj or negedge reinicio) begin
        if (!reinicio) begin
            estado <= ESPERA;
        end else begin
            estado <= estadoSig;
        end
    end

    // Bit timing, shift register, published packet and strobes.
    always_ff @(posedge reloj or negedge reinicio) begin
        if (!reinicio) begin
            ciclo               <= '0;
            indice              <= '0;
            desplazamiento      <= '0;
            bitsRecibidos       <= '0;
            recepcionFinalizada <= 1'b0;
            errorTrama          <= 1'b0;
        end else begin
            ciclo               <= cicloSig;
            indice              <= indiceSig;
            desplazamiento      <= desplazamientoSig;
            bitsRecibidos       <= bitsSig;
            recepcionFinalizada <= finalizadaSig;
            errorTrama          <= errorSig;
        end
    end

    assign identificadorDestino = bitsRecibidos[POS_DESTINO +: ANCHO_CAMPO];
    assign datoRecibido         = bitsRecibidos[POS_DATO +: ANCHO_CAMPO];

endmodule

// File: tb/tb_modulo_receptor_uart.sv
// Self-checking bench for modulo_receptor_uart with 16 cycles per bit:
// a vector table of frames plus hand-written back-to-back, glitch,
// bad-stop/break and mid-frame reset sequences.
module tb_modulo_receptor_uart;

    localparam int C   = 16;
    localparam int H   = C / 2;
    // 2 synchronizer cycles to t0, then t0 + 1 + H + 9C.
    localparam int LAT = 2 + 1 + H + 9 * C;

    logic       reloj = 1'b0;
    logic       reinicio;
    logic       linea;
    logic [7:0] bitsRecibidos;
    logic [3:0] identificadorDestino;
    logic [3:0] datoRecibido;
    logic       recepcionFinalizada;
    logic       errorTrama;

    modulo_receptor_uart #(
        .CICLOS_POR_BIT(C)
    ) dut (
        .reloj               (reloj),
        .reinicio            (reinicio),
        .lineaRecepcionBits  (linea),
        .bitsRecibidos       (bitsRecibidos),
        .identificadorDestino(identificadorDestino),
        .datoRecibido        (datoRecibido),
        .recepcionFinalizada (recepcionFinalizada),
        .errorTrama          (errorTrama)
    );

    always #5 reloj = ~reloj;

    int cyc = 0;
    always @(posedge reloj) cyc <= cyc + 1;

    int errores = 0;
    int checks  = 0;

    typedef struct {
        int         ciclo;
        logic [7:0] bits;
        logic [3:0] id;
        logic [3:0] dt;
    } evento_t;

    typedef struct {
        logic [7:0] dato;
        logic       stop;
        logic       esperaOk;
        logic [7:0] bitsFinales;
    } vector_t;

    evento_t recibidos[$];
    int      errCiclos[$];

    task automatic comparar(input string nombre, input logic [31:0] actual,
                            input logic [31:0] esperado);
        checks++;
        if (actual !== esperado) begin
            errores++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nombre, actual, esperado);
        end
    endtask

    // Record every strobe with its cycle and the outputs seen alongside it.
    always @(negedge reloj) begin
        if (recepcionFinalizada === 1'b1 || errorTrama === 1'b1) begin
            comparar("strobes exclusive", {31'b0, recepcionFinalizada & errorTrama}, 32'd0);
            if (recepcionFinalizada === 1'b1)
                recibidos.push_back('{cyc, bitsRecibidos, identificadorDestino, datoRecibido});
            if (errorTrama === 1'b1)
                errCiclos.push_back(cyc);
        end
    end

    task automatic esperar(input int n);
        repeat (n) @(posedge reloj);
        #1;
    endtask

    task automatic enviarTrama(input logic [7:0] b, input logic stop, output int inicio);
        linea  = 1'b0;
        inicio = cyc;
        esperar(C);
        for (int i = 0; i < 8; i++) begin
            linea = b[i];
            esperar(C);
        end
        linea = stop;
        esperar(C);
    endtask

    task automatic verificarTrama(input string n, input logic [7:0] esp, input int inicio);
        evento_t ev;
        comparar({n, " strobe count"}, 32'(recibidos.size()), 32'd1);
        comparar({n, " error count"}, 32'(errCiclos.size()), 32'd0);
        if (recibidos.size() > 0) begin
            ev = recibidos.pop_front();
            comparar({n, " latency"}, 32'(ev.ciclo - inicio), 32'(LAT));
            comparar({n, " bits"}, 32'(ev.bits), 32'(esp));
            comparar({n, " destino"}, 32'(ev.id), 32'(esp[7:4]));
            comparar({n, " dato"}, 32'(ev.dt), 32'(esp[3:0]));
        end
        recibidos.delete();
        errCiclos.delete();
    endtask

    task automatic verificarError(input string n, input int inicio, input logic [7:0] previo);
        comparar({n, " error count"}, 32'(errCiclos.size()), 32'd1);
        comparar({n, " strobe count"}, 32'(recibidos.size()), 32'd0);
        if (errCiclos.size() > 0)
            comparar({n, " error latency"}, 32'(errCiclos[0] - inicio), 32'(LAT));
        comparar({n, " bits kept"}, 32'(bitsRecibidos), 32'(previo));
        recibidos.delete();
        errCiclos.delete();
    endtask

    vector_t    vectores[7];
    int         ini;
    int         ini2;
    evento_t    e1;
    evento_t    e2;
    logic [7:0] trama;

    initial begin
        vectores[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5};
        vectores[1] = '{8'h00, 1'b1, 1'b1, 8'h00};
        vectores[2] = '{8'hFF, 1'b1, 1'b1, 8'hFF};
        vectores[3] = '{8'h01, 1'b1, 1'b1, 8'h01};
        vectores[4] = '{8'h80, 1'b1, 1'b1, 8'h80};
        vectores[5] = '{8'hC3, 1'b0, 1'b0, 8'h80};
        vectores[6] = '{8'h6E, 1'b1, 1'b1, 8'h6E};

        reinicio = 1'b0;
        linea    = 1'b1;
        esperar(3);
        comparar("reset bits", 32'(bitsRecibidos), 32'd0);
        comparar("reset destino", 32'(identificadorDestino), 32'd0);
        comparar("reset dato", 32'(datoRecibido), 32'd0);
        comparar("reset fin", 32'(recepcionFinalizada), 32'd0);
        comparar("reset err", 32'(errorTrama), 32'd0);
        reinicio = 1'b1;
        esperar(5);

        for (int v = 0; v < 7; v++) begin
            enviarTrama(vectores[v].dato, vectores[v].stop, ini);
            linea = 1'b1;
            esperar(20);
            if (vectores[v].esperaOk)
                verificarTrama($sformatf("vec%0d", v), vectores[v].dato, ini);
            else
                verificarError($sformatf("vec%0d", v), ini, vectores[v].bitsFinales);
            comparar($sformatf("vec%0d final bits", v), 32'(bitsRecibidos),
                     32'(vectores[v].bitsFinales));
        end

        // Back-to-back frames, no idle gap after the first stop bit.
        enviarTrama(8'h3C, 1'b1, ini);
        enviarTrama(8'hF0, 1'b1, ini2);
        linea = 1'b1;
        esperar(20);
        comparar("b2b strobe count", 32'(recibidos.size()), 32'd2);
        if (recibidos.size() == 2) begin
            e1 = recibidos.pop_front();
            e2 = recibidos.pop_front();
            comparar("b2b latency", 32'(e1.ciclo - ini), 32'(LAT));
            comparar("b2b spacing", 32'(e2.ciclo - e1.ciclo), 32'd160);
            comparar("b2b first bits", 32'(e1.bits), 32'h3C);
            comparar("b2b second bits", 32'(e2.bits), 32'hF0);
        end
        comparar("b2b errors", 32'(errCiclos.size()), 32'd0);
        recibidos.delete();
        errCiclos.delete();

        // Short low glitch must be rejected silently.
        linea = 1'b0;
        esperar(5);
        linea = 1'b1;
        esperar(40);
        comparar("glitch strobes", 32'(recibidos.size()), 32'd0);
        comparar("glitch errors", 32'(errCiclos.size()), 32'd0);
        comparar("glitch bits kept", 32'(bitsRecibidos), 32'hF0);
        enviarTrama(8'h12, 1'b1, ini);
        linea = 1'b1;
        esperar(20);
        verificarTrama("after glitch", 8'h12, ini);

        // Bad stop bit followed by a held-low break.
        enviarTrama(8'h77, 1'b0, ini);
        esperar(40);
        linea = 1'b1;
        esperar(20);
        verificarError("break", ini, 8'h12);
        enviarTrama(8'h81, 1'b1, ini);
        linea = 1'b1;
        esperar(20);
        verificarTrama("after break", 8'h81, ini);

        // Reset asserted in the middle of data bit 4.
        trama = 8'h5A;
        linea = 1'b0;
        esperar(C);
        for (int i = 0; i < 4; i++) begin
            linea = trama[i];
            esperar(C);
        end
        linea = trama[4];
        esperar(8);
        reinicio = 1'b0;
        #1;
        comparar("midreset bits", 32'(bitsRecibidos), 32'd0);
        comparar("midreset destino", 32'(identificadorDestino), 32'd0);
        comparar("midreset dato", 32'(datoRecibido), 32'd0);
        comparar("midreset fin", 32'(recepcionFinalizada), 32'd0);
        comparar("midreset err", 32'(errorTrama), 32'd0);
        linea = 1'b1;
        esperar(3);
        reinicio = 1'b1;
        esperar(40);
        comparar("midreset strobes", 32'(recibidos.size()), 32'd0);
        comparar("midreset errors", 32'(errCiclos.size()), 32'd0);
        enviarTrama(8'h5A, 1'b1, ini);
        linea = 1'b1;
        esperar(20);
        verificarTrama("after reset", 8'h5A, ini);

        $display("Result: errors=%0d of %0d checks", errores, checks);
        $finish;
    end

endmodule
